// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: owns the fetch PC, sequences instruction-bus requests,
// defers redirects that land mid-handshake, and filters out responses that
// belong to a killed (pre-redirect) path.
// Optional feature macro: FETCH_BPU_EN (predictor-directed next address).
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter int unsigned MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        bp_fail,
  input  logic [31:0] bp_pc,
  input  logic        bpu_taken,
  input  logic [31:0] bpu_target,
  input  logic        queue_full,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iaddr_ok,
  input  logic        idata_ok,
  input  logic [31:0] idata,
  output logic        resp_valid,
  output logic [31:0] resp_pc,
  output logic [31:0] resp_instr
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1) + 1;
  localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUT);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUT - 1);

  logic [31:0]   r_pc;
  logic          r_req_active;
  logic          r_pend_valid;
  logic [31:0]   r_pend_pc;
  logic [1:0]    r_pend_prio;
  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_kill_cnt;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [31:0]   r_fifo [MAX_OUT];

  logic          w_hard;
  logic [31:0]   w_hard_pc;
  logic [1:0]    w_hard_prio;
  logic          w_accept;
  logic          w_pop;
  logic          w_kill_dec;
  logic [CW-1:0] w_out_cnt_nxt;
  logic [CW-1:0] w_kill_nxt;
  logic [31:0]   w_seq_pc;
  logic [31:0]   w_pc_nxt;
  logic          w_req_nxt;
  logic          w_pend_valid_nxt;
  logic [31:0]   w_pend_pc_nxt;
  logic [1:0]    w_pend_prio_nxt;

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Hard-redirect priority select: exception > ERET > mispredict.
  always_comb begin
    w_hard      = 1'b0;
    w_hard_pc   = '0;
    w_hard_prio = 2'd0;
    if (exc_valid) begin
      w_hard      = 1'b1;
      w_hard_pc   = exc_pc;
      w_hard_prio = 2'd2;
    end else if (eret) begin
      w_hard      = 1'b1;
      w_hard_pc   = epc;
      w_hard_prio = 2'd1;
    end else if (bp_fail) begin
      w_hard      = 1'b1;
      w_hard_pc   = bp_pc;
      w_hard_prio = 2'd0;
    end
  end

`ifdef FETCH_BPU_EN
  assign w_seq_pc = bpu_taken ? bpu_target : r_pc + 32'd4;
`else
  logic w_unused_bpu;
  assign w_unused_bpu = ^{bpu_taken, bpu_target};
  assign w_seq_pc     = r_pc + 32'd4;
`endif

  assign w_accept      = r_req_active & iaddr_ok;
  // A response with nothing outstanding is a protocol error and is dropped.
  assign w_pop         = idata_ok & (r_out_cnt != '0);
  assign w_kill_dec    = w_pop & (r_kill_cnt != '0);
  assign w_out_cnt_nxt = r_out_cnt + CW'(w_accept) - CW'(w_pop);

  // Next-state: fetch PC, pending redirect, issue and kill accounting.
  always_comb begin
    w_pc_nxt         = r_pc;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_pc_nxt    = r_pend_pc;
    w_pend_prio_nxt  = r_pend_prio;
    w_req_nxt        = r_req_active;
    w_kill_nxt       = r_kill_cnt - CW'(w_kill_dec);

    if (w_accept) begin
      w_pend_valid_nxt = 1'b0;
      if (w_hard)            w_pc_nxt = w_hard_pc;
      else if (r_pend_valid) w_pc_nxt = r_pend_pc;
      else                   w_pc_nxt = w_seq_pc;
      // The request just accepted was fetched from the old path.
      if (r_pend_valid) w_kill_nxt = w_kill_nxt + CW'(1);
    end else if (w_hard) begin
      if (r_req_active) begin
        // Address must stay put on the bus; defer the redirect.
        if (!r_pend_valid || (w_hard_prio >= r_pend_prio)) begin
          w_pend_valid_nxt = 1'b1;
          w_pend_pc_nxt    = w_hard_pc;
          w_pend_prio_nxt  = w_hard_prio;
        end
      end else begin
        w_pc_nxt = w_hard_pc;
      end
    end

    // Everything still outstanding after this cycle is on the dead path.
    if (w_hard) w_kill_nxt = w_out_cnt_nxt;

    // An active request holds until accepted; otherwise issue when room.
    if (!r_req_active || w_accept)
      w_req_nxt = !queue_full && (w_out_cnt_nxt < MAX_CNT);
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc         <= RESET_PC;
      r_req_active <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
      r_pend_prio  <= 2'd0;
      r_out_cnt    <= '0;
      r_kill_cnt   <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_req_active <= w_req_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
      r_pend_prio  <= w_pend_prio_nxt;
      r_out_cnt    <= w_out_cnt_nxt;
      r_kill_cnt   <= w_kill_nxt;
      if (w_accept) r_wptr <= f_ptr_inc(r_wptr);
      if (w_pop)    r_rptr <= f_ptr_inc(r_rptr);
    end
  end

  // PC FIFO storage; emptiness is tracked by the pointers and out_cnt.
  always_ff @(posedge clk) begin
    if (w_accept) r_fifo[r_wptr] <= r_pc;
  end

  assign ireq_valid = r_req_active;
  assign ireq_addr  = r_pc;
  assign resp_valid = w_pop && (r_kill_cnt == '0);
  assign resp_pc    = resp_valid ? r_fifo[r_rptr] : '0;
  assign resp_instr = resp_valid ? idata : '0;

  a_no_spurious_resp : assert property (
    @(posedge clk) disable iff (!resetn) idata_ok |-> (r_out_cnt != '0)
  );

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: per-cycle vector table plus reset sequences.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        exc_valid, eret, bp_fail, bpu_taken, queue_full;
  logic [31:0] exc_pc, epc, bp_pc, bpu_target;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iaddr_ok, idata_ok;
  logic [31:0] idata;
  logic        resp_valid;
  logic [31:0] resp_pc, resp_instr;

  fetch_redirect_ctrl #(.RESET_PC(32'hbfc00000), .MAX_OUT(2)) dut (
    .clk(clk), .resetn(resetn),
    .exc_valid(exc_valid), .exc_pc(exc_pc),
    .eret(eret), .epc(epc),
    .bp_fail(bp_fail), .bp_pc(bp_pc),
    .bpu_taken(bpu_taken), .bpu_target(bpu_target),
    .queue_full(queue_full),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iaddr_ok(iaddr_ok), .idata_ok(idata_ok), .idata(idata),
    .resp_valid(resp_valid), .resp_pc(resp_pc), .resp_instr(resp_instr)
  );

  always #5 clk = ~clk;

  // Redirect kinds used in the table
  localparam logic [2:0] RN = 3'd0, RX = 3'd1, RE = 3'd2, RB = 3'd3, RXE = 3'd4;

`ifdef FETCH_BPU_EN
  localparam logic [31:0] P = 32'hbfc00040;
`else
  localparam logic [31:0] P = 32'hbfc00388;
`endif
  localparam logic [31:0] P4 = P + 32'd4;

  typedef struct {
    logic [2:0]  rk;
    logic [31:0] rpc;
    logic        bpt;
    logic        qf;
    logic        aok;
    logic        dok;
    logic [31:0] data;
    logic        e_iv;
    logic [31:0] e_ia;
    logic        e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  localparam int NV = 31;
  vec_t tbl [NV];
  int   n_cmp = 0;
  int   n_err = 0;
  int   row   = -1;

  function automatic vec_t mk(input logic [2:0] rk, input logic [31:0] rpc,
                              input logic bpt, input logic qf, input logic aok,
                              input logic dok, input logic [31:0] data,
                              input logic e_iv, input logic [31:0] e_ia,
                              input logic e_rv, input logic [31:0] e_rpc);
    vec_t v;
    v.rk = rk; v.rpc = rpc; v.bpt = bpt; v.qf = qf; v.aok = aok; v.dok = dok;
    v.data = data; v.e_iv = e_iv; v.e_ia = e_ia; v.e_rv = e_rv; v.e_rpc = e_rpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (row %0d): got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic idle_inputs();
    exc_valid = 1'b0; exc_pc = '0; eret = 1'b0; epc = '0;
    bp_fail = 1'b0; bp_pc = '0; bpu_taken = 1'b0; bpu_target = 32'hbfc00040;
    queue_full = 1'b0; iaddr_ok = 1'b0; idata_ok = 1'b0; idata = '0;
  endtask

  task automatic apply(input vec_t v);
    exc_valid  = (v.rk == RX) || (v.rk == RXE);
    exc_pc     = v.rpc;
    eret       = (v.rk == RE) || (v.rk == RXE);
    epc        = (v.rk == RXE) ? 32'h80001000 : v.rpc;
    bp_fail    = (v.rk == RB);
    bp_pc      = v.rpc;
    bpu_taken  = v.bpt;
    queue_full = v.qf;
    iaddr_ok   = v.aok;
    idata_ok   = v.dok;
    idata      = v.data;
  endtask

  initial begin
    // rk rpc bpt qf aok dok data | iv ia rv rpc
    // sequential fetch with 1-cycle response
    tbl[0]  = mk(RN, 0, 0,0,0,0, 32'h0,        0, 32'hbfc00000, 0, 0);
    tbl[1]  = mk(RN, 0, 0,0,1,0, 32'h0,        1, 32'hbfc00000, 0, 0);
    tbl[2]  = mk(RN, 0, 0,0,1,1, 32'h10000002, 1, 32'hbfc00004, 1, 32'hbfc00000);
    tbl[3]  = mk(RN, 0, 0,0,1,1, 32'h10000003, 1, 32'hbfc00008, 1, 32'hbfc00004);
    tbl[4]  = mk(RN, 0, 0,0,0,1, 32'h10000004, 1, 32'hbfc0000c, 1, 32'hbfc00008);
    // mispredict during stalled handshake
    tbl[5]  = mk(RB, 32'hbfc00100, 0,0,0,0, 0, 1, 32'hbfc0000c, 0, 0);
    tbl[6]  = mk(RN, 0, 0,0,0,0, 32'h0,        1, 32'hbfc0000c, 0, 0);
    tbl[7]  = mk(RN, 0, 0,0,1,0, 32'h0,        1, 32'hbfc0000c, 0, 0);
    tbl[8]  = mk(RN, 0, 0,0,1,1, 32'h10000008, 1, 32'hbfc00100, 0, 0);
    tbl[9]  = mk(RN, 0, 0,0,0,1, 32'h10000009, 1, 32'hbfc00104, 1, 32'hbfc00100);
    // two in flight, then exception while idle
    tbl[10] = mk(RN, 0, 0,0,1,0, 32'h0,        1, 32'hbfc00104, 0, 0);
    tbl[11] = mk(RN, 0, 0,0,1,0, 32'h0,        1, 32'hbfc00108, 0, 0);
    tbl[12] = mk(RX, 32'hbfc00380, 0,0,0,0, 0, 0, 32'hbfc0010c, 0, 0);
    tbl[13] = mk(RN, 0, 0,0,0,1, 32'h1000000d, 0, 32'hbfc00380, 0, 0);
    tbl[14] = mk(RN, 0, 0,0,1,1, 32'h1000000e, 1, 32'hbfc00380, 0, 0);
    tbl[15] = mk(RN, 0, 0,0,0,1, 32'h1000000f, 1, 32'hbfc00384, 1, 32'hbfc00380);
    // exception and ERET together while stalled
    tbl[16] = mk(RXE, 32'hbfc00380, 0,0,0,0, 0, 1, 32'hbfc00384, 0, 0);
    tbl[17] = mk(RN, 0, 0,0,1,0, 32'h0,        1, 32'hbfc00384, 0, 0);
    tbl[18] = mk(RN, 0, 0,0,0,1, 32'h10000012, 1, 32'hbfc00380, 0, 0);
    // queue_full while request pending
    tbl[19] = mk(RN, 0, 0,1,0,0, 32'h0,        1, 32'hbfc00380, 0, 0);
    tbl[20] = mk(RN, 0, 0,1,1,0, 32'h0,        1, 32'hbfc00380, 0, 0);
    tbl[21] = mk(RN, 0, 0,1,0,1, 32'h10000015, 0, 32'hbfc00384, 1, 32'hbfc00380);
    tbl[22] = mk(RN, 0, 0,0,0,0, 32'h0,        0, 32'hbfc00384, 0, 0);
    tbl[23] = mk(RN, 0, 0,0,0,0, 32'h0,        1, 32'hbfc00384, 0, 0);
    // predictor taken on accept
    tbl[24] = mk(RN, 0, 1,0,1,0, 32'h0,        1, 32'hbfc00384, 0, 0);
    tbl[25] = mk(RN, 0, 0,0,0,1, 32'h10000019, 1, P,            1, 32'hbfc00384);
    // accept + response + mispredict in the same cycle
    tbl[26] = mk(RN, 0, 0,0,1,0, 32'h0,        1, P,            0, 0);
    tbl[27] = mk(RB, 32'hbfc00200, 0,0,1,1, 32'h1000001b, 1, P4, 1, P);
    tbl[28] = mk(RN, 0, 0,0,0,1, 32'h1000001c, 1, 32'hbfc00200, 0, 0);
    tbl[29] = mk(RN, 0, 0,0,1,0, 32'h0,        1, 32'hbfc00200, 0, 0);
    tbl[30] = mk(RN, 0, 0,0,0,1, 32'h1000001e, 1, 32'hbfc00204, 1, 32'hbfc00200);

    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_ireq_valid", 32'(ireq_valid), 32'd0);
    chk("reset_ireq_addr",  ireq_addr,       32'hbfc00000);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_pc",    resp_pc,         32'd0);
    chk("reset_resp_instr", resp_instr,      32'd0);

    resetn = 1'b1;
    for (int i = 0; i < NV; i++) begin
      row = i;
      apply(tbl[i]);
      #1;
      chk("ireq_valid", 32'(ireq_valid), 32'(tbl[i].e_iv));
      chk("ireq_addr",  ireq_addr,       tbl[i].e_ia);
      chk("resp_valid", 32'(resp_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) begin
        chk("resp_pc",    resp_pc,    tbl[i].e_rpc);
        chk("resp_instr", resp_instr, tbl[i].data);
      end
      @(negedge clk);
    end

    // Reset while a request is in flight discards everything.
    row = 100;
    idle_inputs();
    iaddr_ok = 1'b1;
    #1;
    chk("midop_pre_valid", 32'(ireq_valid), 32'd1);
    @(negedge clk);
    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    #1;
    chk("midop_reset_valid", 32'(ireq_valid), 32'd0);
    chk("midop_reset_addr",  ireq_addr,       32'hbfc00000);
    resetn = 1'b1;

    // First request must come up within a bounded number of cycles.
    row = 101;
    begin
      int waited;
      waited = 0;
      while (!ireq_valid && waited < 4) begin
        @(negedge clk);
        #1;
        waited++;
      end
      chk("restart_valid",   32'(ireq_valid), 32'd1);
      chk("restart_latency", 32'(waited),     32'd1);
      chk("restart_addr",    ireq_addr,       32'hbfc00000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
